regfile: RTL and testbench

//   RISC-V integer register file: 32 x 32-bit general-purpose registers

---
 rtl/regfile.sv | 40 ++++
 tb/tb_regfile.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// RISC-V integer register file: 32 x XLEN registers with two combinational read
// ports and one synchronous write port. Register x0 always reads as zero.
`timescale 1ns/1ps

module regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   rd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [XLEN-1:0]   r1_out,
  output logic [XLEN-1:0]   r2_out
);

  logic [XLEN-1:0] registers [0:NREGS-1];

  // NOTE: the array is built from flops, not a RAM macro, because every entry
  // must clear asynchronously; a RAM-style array cannot be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        registers[i] <= '0;
      end
    end else if (w_en && (rd_addr != '0)) begin
      // NOTE: non-blocking so every read port sees the pre-edge value this cycle.
      registers[rd_addr] <= rd;
    end
  end

  // No write bypass: a colliding read sees the old value until the edge.
  assign r1_out = registers[r1_addr];
  assign r2_out = registers[r2_addr];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model of the architectural state.
`timescale 1ns/1ps

module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd;
  logic [4:0]  rd_addr;
  logic        w_en;
  logic [4:0]  r1_addr;
  logic [4:0]  r2_addr;
  logic [31:0] r1_out;
  logic [31:0] r2_out;

  logic [31:0] model [0:31];
  int n_tests = 0;
  int n_fail  = 0;

  regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd      (rd),
    .rd_addr (rd_addr),
    .w_en    (w_en),
    .r1_addr (r1_addr),
    .r2_addr (r2_addr),
    .r1_out  (r1_out),
    .r2_out  (r2_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Architectural write rule applied at a rising edge.
  task automatic model_edge();
    if (rst_n === 1'b1 && w_en === 1'b1 && rd_addr != 5'd0) model[rd_addr] = rd;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    r1_addr = a1;
    r2_addr = a2;
    #0.2;
    check($sformatf("%s r1[%0d]", tag, a1), r1_out, model[a1]);
    check($sformatf("%s r2[%0d]", tag, a2), r2_out, model[a2]);
  endtask

  // Drive a write at the falling edge and let the next rising edge commit it.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    rd_addr = a;
    rd      = d;
    w_en    = en;
    @(posedge clk);
    model_edge();
    #1;
    w_en = 1'b0;
  endtask

  task automatic check_array(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s reg[%0d]", tag, i), dut.registers[i], model[i]);
    end
  endtask

  logic [31:0] seq_vals [0:6];

  initial begin
    seq_vals = '{32'hfefe, 32'habba, 32'h1313, 32'hbadd, 32'heafd, 32'hbbbb, 32'h6969};
    rst_n = 1'b1; rd = '0; rd_addr = '0; w_en = 1'b0; r1_addr = '0; r2_addr = '0;

    // Reset pulse in the middle of a cycle; clearing must not wait for a clock.
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check("reset_async r1", r1_out, 32'h0);
    #1 rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      read_check("reset", 5'(a), 5'(31 - a));
    end

    // Sequential writes to x1..x7 on consecutive edges.
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rd_addr = 5'(i + 1);
      rd      = seq_vals[i];
      w_en    = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
    end
    w_en = 1'b0;
    check_array("seq");

    // Dual reads: both ports change address together, no edge in between.
    @(negedge clk);
    read_check("dual_a", 5'd1, 5'd2);
    read_check("dual_b", 5'd3, 5'd4);
    read_check("same_reg", 5'd6, 5'd6);

    // x0 cannot be written.
    do_write(5'd0, 32'hdeadbeef, 1'b1);
    read_check("x0", 5'd0, 5'd0);

    // Write disabled: x1 keeps its value.
    do_write(5'd1, 32'h1234, 1'b0);
    read_check("wen_off", 5'd1, 5'd1);

    // Collision: old value before the edge, new value after it.
    @(negedge clk);
    r1_addr = 5'd5; r2_addr = 5'd5;
    rd_addr = 5'd5; rd = 32'h5555; w_en = 1'b1;
    #1;
    check("collide_pre", r1_out, model[5]);
    @(posedge clk);
    model_edge();
    #1;
    w_en = 1'b0;
    check("collide_post", r1_out, 32'h5555);
    check("collide_post r2", r2_out, model[5]);

    // Randomized traffic: reads checked both before and after each edge.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rd_addr = 5'($urandom_range(0, 31));
      rd      = $urandom;
      w_en    = 1'($urandom_range(0, 3) != 0);
      r1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      r2_addr = 5'($urandom_range(0, 31));
      #1;
      check("rand_pre r1", r1_out, model[r1_addr]);
      check("rand_pre r2", r2_out, model[r2_addr]);
      @(posedge clk);
      model_edge();
      #1;
      check("rand_post r1", r1_out, model[r1_addr]);
      check("rand_post r2", r2_out, model[r2_addr]);
    end
    w_en = 1'b0;
    check_array("rand");

    // Async reset mid-run, with a write attempted while reset is held.
    @(negedge clk);
    r1_addr = 5'd7; r2_addr = 5'd5;
    rd_addr = 5'd9; rd = 32'hcafef00d; w_en = 1'b1;
    #1 rst_n = 1'b0;
    model_clear();
    #0.5;
    check("rst_mid r1", r1_out, 32'h0);
    check("rst_mid r2", r2_out, 32'h0);
    @(posedge clk);
    model_edge();
    #1;
    check("rst_write_lost", dut.registers[9], 32'h0);
    w_en = 1'b0;
    #2 rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      read_check("post_rst", 5'(a), 5'(a ^ 5'h1f));
    end

    // Writes work again after reset release.
    do_write(5'd9, 32'h0badf00d, 1'b1);
    read_check("after_rst", 5'd9, 5'd0);
    check_array("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
